// File: rtl/ysyx_24100006_lsu_axi_master.sv
// AXI-Lite initiator for the LSU: one request at a time, load byte-lane alignment and extension,
// store lane shifting/strobes, bus-error and misalignment reporting.
module ysyx_24100006_lsu_axi_master #(
  parameter bit MISALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] axi_araddr,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rvalid,
  input  logic        axi_rlast,
  output logic        axi_rready,
  output logic [31:0] axi_awaddr,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  input  logic [1:0]  axi_bresp,
  input  logic        axi_bvalid,
  output logic        axi_bready
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_RESP} state_t;

  state_t      state;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        aw_done;
  logic        w_done;
  logic        req_mis;
  logic [3:0]  strb_base;
  logic        aw_fin;
  logic        w_fin;
  logic        unused_rlast;

  assign unused_rlast = axi_rlast;
  assign req_ready    = (state == S_IDLE);
  assign aw_fin       = aw_done | (axi_awvalid & axi_awready);
  assign w_fin        = w_done | (axi_wvalid & axi_wready);

  always_comb begin
    req_mis   = 1'b0;
    strb_base = 4'b1111;
    case (req_size)
      2'd0: strb_base = 4'b0001;
      2'd1: begin
        strb_base = 4'b0011;
        req_mis   = req_addr[0];
      end
      default: req_mis = |req_addr[1:0];
    endcase
  end

  // Shift the addressed lane down, keep 8/16/32 bits, then sign/zero extend.
  function automatic logic [31:0] load_ext(input logic [31:0] data, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [31:0] raw;
    raw = data >> {off, 3'b000};
    case (size)
      2'd0:    return uns ? {24'b0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
      2'd1:    return uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      off_q       <= 2'b0;
      size_q      <= 2'b0;
      uns_q       <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'b0;
      resp_err    <= 1'b0;
      axi_araddr  <= 32'b0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      axi_awaddr  <= 32'b0;
      axi_awvalid <= 1'b0;
      axi_wdata   <= 32'b0;
      axi_wstrb   <= 4'b0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            off_q  <= req_addr[1:0];
            size_q <= req_size;
            uns_q  <= req_unsigned;
            if (MISALIGN_CHECK && req_mis) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'b0;
            end else if (req_wen) begin
              state       <= S_AW_W;
              axi_awaddr  <= req_addr;
              axi_awvalid <= 1'b1;
              axi_wdata   <= req_wdata << {req_addr[1:0], 3'b000};
              axi_wstrb   <= strb_base << req_addr[1:0];
              axi_wvalid  <= 1'b1;
              aw_done     <= 1'b0;
              w_done      <= 1'b0;
            end else begin
              state       <= S_AR;
              axi_araddr  <= req_addr;
              axi_arvalid <= 1'b1;
            end
          end
        end
        S_AR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state       <= S_R;
          end
        end
        S_R: begin
          if (axi_rvalid) begin
            axi_rready <= 1'b0;
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= (axi_rresp != 2'b00);
            resp_rdata <= (axi_rresp != 2'b00) ? 32'b0 : load_ext(axi_rdata, off_q, size_q, uns_q);
          end
        end
        S_AW_W: begin
          // Each channel retires independently; move on once both have handshaken.
          if (axi_awvalid && axi_awready) axi_awvalid <= 1'b0;
          if (axi_wvalid && axi_wready) axi_wvalid <= 1'b0;
          aw_done <= aw_fin;
          w_done  <= w_fin;
          if (aw_fin && w_fin) begin
            state      <= S_B;
            axi_bready <= 1'b1;
          end
        end
        S_B: begin
          if (axi_bvalid) begin
            axi_bready <= 1'b0;
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= (axi_bresp != 2'b00);
            resp_rdata <= 32'b0;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_lsu_axi_master.sv
// Bench for the LSU AXI-Lite master: directed cases plus random loads/stores against a
// byte-level reference model with scripted slave timing.
module tb_ysyx_24100006_lsu_axi_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rlast, axi_rready;
  logic [1:0]  axi_rresp, axi_bresp;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic [3:0]  axi_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_24100006_lsu_axi_master #(.MISALIGN_CHECK(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .axi_rlast(axi_rlast), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_mis(input logic [31:0] addr, input logic [1:0] size);
    return (addr % nbytes(size)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                           input logic uns, input logic [31:0] rd);
    longint unsigned v;
    int nb, off;
    nb  = nbytes(size);
    off = addr % 4;
    v   = rd;
    v   = v / (64'd1 << (8 * off));
    v   = v % (64'd1 << (8 * nb));
    if (!uns && nb < 4 && v >= (64'd1 << (8 * nb - 1)))
      v = v + (64'd1 << 32) - (64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] addr, input logic [31:0] wd);
    longint unsigned v;
    v = wd;
    v = v * (64'd1 << (8 * (addr % 4)));
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_strb(input logic [31:0] addr, input logic [1:0] size);
    logic [3:0] s;
    int off;
    s   = 4'b0;
    off = addr % 4;
    for (int i = off; i < off + nbytes(size); i++) if (i < 4) s[i] = 1'b1;
    return s;
  endfunction

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    tick;
    // Scramble request fields so the DUT must rely on its latched copy.
    req_valid = 1'b0; req_addr = $urandom; req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_wdata = $urandom; req_wen = 1'($urandom);
  endtask

  task automatic chk_mis;
    chk("mis_resp_valid", resp_valid, 1);
    chk("mis_resp_err", resp_err, 1);
    chk("mis_resp_rdata", resp_rdata, 0);
    chk("mis_no_arvalid", axi_arvalid, 0);
    chk("mis_no_awvalid", axi_awvalid, 0);
    tick;
    chk("mis_resp_pulse", resp_valid, 0);
    chk("mis_req_ready", req_ready, 1);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                         input logic [31:0] rd, input logic [1:0] rr, input int ar_dly,
                         input int r_dly);
    issue(1'b0, addr, size, uns, 32'h0);
    if (is_mis(addr, size)) begin
      chk_mis;
      return;
    end
    for (int c = 0; c <= ar_dly; c++) begin
      chk("ld_arvalid", axi_arvalid, 1);
      chk("ld_araddr", axi_araddr, addr);
      chk("ld_rready_early", axi_rready, 0);
      chk("ld_resp_early", resp_valid, 0);
      axi_arready = (c == ar_dly);
      tick;
    end
    axi_arready = 1'b0;
    for (int c = 0; c <= r_dly; c++) begin
      chk("ld_arvalid_drop", axi_arvalid, 0);
      chk("ld_rready", axi_rready, 1);
      chk("ld_resp_early", resp_valid, 0);
      if (c == r_dly) begin
        axi_rvalid = 1'b1; axi_rdata = rd; axi_rresp = rr;
      end
      tick;
    end
    axi_rvalid = 1'b0; axi_rdata = $urandom; axi_rresp = 2'($urandom);
    chk("ld_resp_valid", resp_valid, 1);
    chk("ld_resp_err", resp_err, (rr != 2'b00));
    chk("ld_resp_rdata", resp_rdata, (rr != 2'b00) ? 32'h0 : ref_load(addr, size, uns, rd));
    chk("ld_rready_drop", axi_rready, 0);
    tick;
    chk("ld_resp_pulse", resp_valid, 0);
    chk("ld_req_ready", req_ready, 1);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd,
                          input logic [1:0] br, input int aw_dly, input int w_dly,
                          input int b_dly);
    bit awd, wd_done;
    int c;
    issue(1'b1, addr, size, 1'b0, wd);
    if (is_mis(addr, size)) begin
      chk_mis;
      return;
    end
    awd = 1'b0; wd_done = 1'b0; c = 0;
    while (!(awd && wd_done)) begin
      chk("st_awvalid", axi_awvalid, !awd);
      chk("st_wvalid", axi_wvalid, !wd_done);
      chk("st_bready_early", axi_bready, 0);
      if (!awd) chk("st_awaddr", axi_awaddr, addr);
      if (!wd_done) begin
        chk("st_wdata", axi_wdata, ref_wdata(addr, wd));
        chk("st_wstrb", axi_wstrb, ref_strb(addr, size));
      end
      axi_awready = (c == aw_dly);
      axi_wready  = (c == w_dly);
      tick;
      if (c == aw_dly) awd = 1'b1;
      if (c == w_dly) wd_done = 1'b1;
      c++;
    end
    axi_awready = 1'b0; axi_wready = 1'b0;
    for (int k = 0; k <= b_dly; k++) begin
      chk("st_bready", axi_bready, 1);
      chk("st_awvalid_drop", axi_awvalid, 0);
      chk("st_wvalid_drop", axi_wvalid, 0);
      chk("st_resp_early", resp_valid, 0);
      if (k == b_dly) begin
        axi_bvalid = 1'b1; axi_bresp = br;
      end
      tick;
    end
    axi_bvalid = 1'b0; axi_bresp = 2'($urandom);
    chk("st_resp_valid", resp_valid, 1);
    chk("st_resp_err", resp_err, (br != 2'b00));
    chk("st_resp_rdata", resp_rdata, 0);
    chk("st_bready_drop", axi_bready, 0);
    tick;
    chk("st_resp_pulse", resp_valid, 0);
    chk("st_req_ready", req_ready, 1);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_size = 2'd0; req_unsigned = 1'b0;
    axi_arready = 1'b0; axi_rdata = 32'h0; axi_rresp = 2'b00; axi_rvalid = 1'b0;
    axi_rlast = 1'b1; axi_awready = 1'b0; axi_wready = 1'b0; axi_bresp = 2'b00;
    axi_bvalid = 1'b0;
    tick;
    tick;
    reset = 1'b0;

    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_arvalid", axi_arvalid, 0);
    chk("rst_araddr", axi_araddr, 0);
    chk("rst_rready", axi_rready, 0);
    chk("rst_awvalid", axi_awvalid, 0);
    chk("rst_awaddr", axi_awaddr, 0);
    chk("rst_wvalid", axi_wvalid, 0);
    chk("rst_wdata", axi_wdata, 0);
    chk("rst_wstrb", axi_wstrb, 0);
    chk("rst_bready", axi_bready, 0);

    // Directed cases: CLINT-style word load, signed/unsigned byte, halfword store, errors.
    do_load(32'h0200_0000, 2'd2, 1'b0, 32'h0000_1234, 2'b00, 1, 0);
    do_load(32'h8000_0003, 2'd0, 1'b0, 32'h80AB_CDEF, 2'b00, 0, 0);
    do_load(32'h8000_0003, 2'd0, 1'b1, 32'h80AB_CDEF, 2'b00, 0, 0);
    do_store(32'h8000_0002, 2'd1, 32'h0000_BEEF, 2'b00, 2, 0, 0);
    do_store(32'h8000_0000, 2'd2, 32'h1234_5678, 2'b01, 0, 0, 1);
    do_load(32'h8000_0000, 2'd2, 1'b0, 32'hDEAD_BEEF, 2'b01, 0, 2);
    do_load(32'h8000_0002, 2'd2, 1'b0, 32'h0, 2'b00, 0, 0);

    // Stray responses while idle must be ignored.
    axi_rvalid = 1'b1; axi_bvalid = 1'b1;
    tick;
    chk("stray_rready", axi_rready, 0);
    chk("stray_bready", axi_bready, 0);
    tick;
    chk("stray_resp", resp_valid, 0);
    axi_rvalid = 1'b0; axi_bvalid = 1'b0;
    chk("stray_req_ready", req_ready, 1);

    // Reset while waiting in the read-data phase.
    issue(1'b0, 32'h8000_0010, 2'd2, 1'b0, 32'h0);
    axi_arready = 1'b1;
    tick;
    axi_arready = 1'b0;
    chk("mid_rready", axi_rready, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mid_arvalid", axi_arvalid, 0);
    chk("mid_rready_clr", axi_rready, 0);
    chk("mid_awvalid", axi_awvalid, 0);
    chk("mid_wvalid", axi_wvalid, 0);
    chk("mid_bready", axi_bready, 0);
    chk("mid_req_ready", req_ready, 1);
    chk("mid_resp_valid", resp_valid, 0);
    tick;
    chk("mid_resp_after", resp_valid, 0);
    do_load(32'h8000_0010, 2'd1, 1'b0, 32'h1234_8001, 2'b00, 0, 0);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, d;
      logic [1:0]  sz, xr;
      a  = $urandom;
      d  = $urandom;
      sz = 2'($urandom);
      xr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 1) == 1)
        do_store(a, sz, d, xr, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        do_load(a, sz, 1'($urandom), d, xr, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
